// File: rtl/fitbit_defs.sv
// Shared definitions for the step pipeline (stepCounter, distanceCovered, activity_monitor):
// FSM encodings, steps-per-second width, default timing and rate constants.
package fitbit_defs;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  localparam int unsigned STEPS_W             = 8;
  localparam int unsigned FAST_W              = 4;
  localparam int unsigned DEF_TICKS_PER_SEC   = 100_000_000;
  localparam int unsigned DEF_FAST_RATE       = 32;
  localparam int unsigned DEF_EARLY_WINDOW    = 9;
  localparam int unsigned DEF_HIGH_RATE       = 64;
  localparam int unsigned DEF_HIGH_MIN_RUN    = 60;
  localparam int unsigned DEF_TIME_W          = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // Increment a step count by one when en is set, holding at all-ones.
  function automatic logic [STEPS_W-1:0] sat_inc(input logic [STEPS_W-1:0] v, input logic en);
    if (en && (v != '1)) begin
      return v + STEPS_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge step strobe from the X level. With STEP_DEBOUNCE_EN defined, X is
// synchronized and debounced first; otherwise a single history flop gives 1-cycle latency.
module step_edge_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic strobe
);

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1;
  logic             sync2;
  logic             filt;
  logic             filt_q;
  logic [CNT_W-1:0] cnt;
  logic             strobe_q;

  // Filtered level only follows sync2 after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt     <= 1'b0;
      filt_q   <= 1'b0;
      cnt      <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync1    <= x;
      sync2    <= sync1;
      filt_q   <= filt;
      strobe_q <= filt & ~filt_q;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign strobe = strobe_q;
`else
  logic x_q;
  logic strobe_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q      <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      x_q      <= x;
      strobe_q <= x & ~x_q;
    end
  end

  assign strobe = strobe_q;
`endif

endmodule

// File: rtl/activity_monitor.sv
// Per-second step rate, early fast-second count and high-activity time accumulation.
// Optional STEP_DEBOUNCE_EN adds a synchronizer/debouncer inside step_edge_detect.
module activity_monitor
  import fitbit_defs::*;
#(
  parameter int unsigned TICKS_PER_SEC   = DEF_TICKS_PER_SEC,
  parameter int unsigned FAST_RATE       = DEF_FAST_RATE,
  parameter int unsigned EARLY_WINDOW    = DEF_EARLY_WINDOW,
  parameter int unsigned HIGH_RATE       = DEF_HIGH_RATE,
  parameter int unsigned HIGH_MIN_RUN    = DEF_HIGH_MIN_RUN,
  parameter int unsigned TIME_W          = DEF_TIME_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               clk100MHz,
  input  logic               reset,
  input  logic               X,
  output logic               sec_tick,
  output logic [STEPS_W-1:0] steps_last_sec,
  output logic [FAST_W-1:0]  fast_seconds,
  output logic [TIME_W-1:0]  high_activity_time,
  output logic               high_active
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned RUN_W   = $clog2(HIGH_MIN_RUN + 1);
  localparam int unsigned EL_W    = $clog2(EARLY_WINDOW + 1);

  logic [PRESC_W-1:0] presc;
  logic [STEPS_W-1:0] win_cnt;
  logic [EL_W-1:0]    elapsed;
  logic [RUN_W-1:0]   run;
  state_e             state;
  logic               strobe;

  logic [STEPS_W-1:0] closing_c;
  logic               q_c;
  logic               fast_c;
  logic [TIME_W-1:0]  hat_add_c;
  logic [TIME_W:0]    hat_sum_c;
  logic [TIME_W-1:0]  hat_sat_c;

  step_edge_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_edge (
    .clk   (clk100MHz),
    .reset (reset),
    .x     (X),
    .strobe(strobe)
  );

  assign sec_tick = (presc == PRESC_W'(TICKS_PER_SEC - 1));

  // Closing count includes a strobe landing in the tick cycle itself.
  always_comb begin
    closing_c = sat_inc(win_cnt, strobe);
    q_c       = (closing_c >= STEPS_W'(HIGH_RATE));
    fast_c    = (elapsed < EL_W'(EARLY_WINDOW)) && (closing_c > STEPS_W'(FAST_RATE));
    hat_add_c = (state == ACTIVE) ? TIME_W'(1) : TIME_W'(HIGH_MIN_RUN);
    hat_sum_c = {1'b0, high_activity_time} + {1'b0, hat_add_c};
    hat_sat_c = hat_sum_c[TIME_W] ? '1 : hat_sum_c[TIME_W-1:0];
  end

  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      presc <= '0;
    end else if (sec_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Window counting and per-second statistics.
  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      win_cnt        <= '0;
      steps_last_sec <= '0;
      fast_seconds   <= '0;
      elapsed        <= '0;
    end else if (sec_tick) begin
      steps_last_sec <= closing_c;
      win_cnt        <= '0;
      if (fast_c) begin
        fast_seconds <= fast_seconds + FAST_W'(1);
      end
      if (elapsed < EL_W'(EARLY_WINDOW)) begin
        elapsed <= elapsed + EL_W'(1);
      end
    end else begin
      win_cnt <= sat_inc(win_cnt, strobe);
    end
  end

  // High-activity FSM; entering ACTIVE credits the whole qualifying run at once.
  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      state              <= IDLE;
      run                <= '0;
      high_activity_time <= '0;
      high_active        <= 1'b0;
    end else if (sec_tick) begin
      case (state)
        IDLE: begin
          if (q_c) begin
            run   <= RUN_W'(1);
            state <= CANDIDATE;
          end
        end
        CANDIDATE: begin
          if (!q_c) begin
            run   <= '0;
            state <= IDLE;
          end else if (run == RUN_W'(HIGH_MIN_RUN - 1)) begin
            state              <= ACTIVE;
            high_active        <= 1'b1;
            high_activity_time <= hat_sat_c;
          end else begin
            run <= run + RUN_W'(1);
          end
        end
        ACTIVE: begin
          if (q_c) begin
            high_activity_time <= hat_sat_c;
          end else begin
            run         <= '0;
            state       <= IDLE;
            high_active <= 1'b0;
          end
        end
        default: begin
          run         <= '0;
          state       <= IDLE;
          high_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activity_monitor.sv
// Bench for activity_monitor: a second-level reference model pushes expected
// per-second results that are compared when the DUT ticks.
module tb_activity_monitor;

  localparam int TPS      = 120;
  localparam int FAST     = 8;
  localparam int EARLY    = 9;
  localparam int HIGH     = 10;
  localparam int MIN_RUN  = 3;
  localparam int TW       = 20;
  localparam int HAT_MAX  = (1 << TW) - 1;

  typedef struct {
    int steps;
    int fast;
    int hat;
    bit active;
  } exp_t;

  logic          clk100MHz = 1'b0;
  logic          reset     = 1'b0;
  logic          X         = 1'b0;
  logic          sec_tick;
  logic [7:0]    steps_last_sec;
  logic [3:0]    fast_seconds;
  logic [TW-1:0] high_activity_time;
  logic          high_active;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int cyc;
  int m_win, m_fast, m_elapsed, m_state, m_run, m_hat;
  bit m_xlast, m_rise_prev, check_next;

  activity_monitor #(
    .TICKS_PER_SEC  (TPS),
    .FAST_RATE      (FAST),
    .EARLY_WINDOW   (EARLY),
    .HIGH_RATE      (HIGH),
    .HIGH_MIN_RUN   (MIN_RUN),
    .TIME_W         (TW),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk100MHz         (clk100MHz),
    .reset             (reset),
    .X                 (X),
    .sec_tick          (sec_tick),
    .steps_last_sec    (steps_last_sec),
    .fast_seconds      (fast_seconds),
    .high_activity_time(high_activity_time),
    .high_active       (high_active)
  );

  always #5 clk100MHz = ~clk100MHz;

  function automatic void model_clear();
    cyc = 0; m_win = 0; m_fast = 0; m_elapsed = 0; m_state = 0; m_run = 0; m_hat = 0;
    m_xlast = 1'b0; m_rise_prev = 1'b0; check_next = 1'b0;
    sb.delete();
  endfunction

  // Second-level model of the statistics and the high-activity state machine.
  function automatic void model_second(input int closing);
    exp_t e;
    bit q;
    q = (closing >= HIGH);
    if (m_elapsed < EARLY && closing > FAST) m_fast++;
    if (m_elapsed < EARLY) m_elapsed++;
    case (m_state)
      0: if (q) begin m_run = 1; m_state = 1; end
      1: begin
        if (!q) begin m_run = 0; m_state = 0; end
        else if (m_run + 1 == MIN_RUN) begin
          m_state = 2;
          m_hat = (m_hat + MIN_RUN > HAT_MAX) ? HAT_MAX : m_hat + MIN_RUN;
        end else m_run++;
      end
      default: begin
        if (q) m_hat = (m_hat + 1 > HAT_MAX) ? HAT_MAX : m_hat + 1;
        else begin m_run = 0; m_state = 0; end
      end
    endcase
    e.steps = closing; e.fast = m_fast; e.hat = m_hat; e.active = (m_state == 2);
    sb.push_back(e);
  endfunction

  function automatic bit pat(input int c, input int period, input int rise_at);
    if (period > 0) return ((c / period) % 2) == 0;
    if (rise_at >= 0) return c >= rise_at;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk100MHz);
    reset = 1'b0;
    X = 1'b0;
    repeat (2) @(posedge clk100MHz);
    @(negedge clk100MHz);
    reset = 1'b1;
    model_clear();
  endtask

  // Runs n cycles from the current negedge; checks sec_tick every cycle and the
  // registered outputs on the cycle after each DUT tick.
  task automatic run_cycles(input int n, input int period, input int rise_at);
    exp_t e;
    bit exp_tick, xv;
    for (int i = 0; i < n; i++) begin
      if (check_next) begin
        check_next = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty cyc=%0d got=unexpected tick required=no tick", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (steps_last_sec !== 8'(e.steps)) begin
            errors++;
            $display("FAIL steps_last_sec cyc=%0d got=%0d required=%0d", cyc, steps_last_sec, e.steps);
          end
          checks++;
          if (fast_seconds !== 4'(e.fast)) begin
            errors++;
            $display("FAIL fast_seconds cyc=%0d got=%0d required=%0d", cyc, fast_seconds, e.fast);
          end
          checks++;
          if (high_activity_time !== TW'(e.hat)) begin
            errors++;
            $display("FAIL high_activity_time cyc=%0d got=%0d required=%0d", cyc, high_activity_time, e.hat);
          end
          checks++;
          if (high_active !== e.active) begin
            errors++;
            $display("FAIL high_active cyc=%0d got=%0b required=%0b", cyc, high_active, e.active);
          end
        end
      end
      if (m_rise_prev && m_win < 255) m_win++;
      exp_tick = ((cyc % TPS) == TPS - 1);
      checks++;
      if (sec_tick !== exp_tick) begin
        errors++;
        $display("FAIL sec_tick cyc=%0d got=%0b required=%0b", cyc, sec_tick, exp_tick);
      end
      if (sec_tick === 1'b1) check_next = 1'b1;
      if (exp_tick) begin
        model_second(m_win);
        m_win = 0;
      end
      xv = pat(cyc, period, rise_at);
      m_rise_prev = xv && !m_xlast;
      m_xlast = xv;
      X = xv;
      @(negedge clk100MHz);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sec_tick, steps_last_sec, fast_seconds, high_activity_time, high_active} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%0d/%0d/%0d/%0d/%0d required=all 0", sec_tick, steps_last_sec,
               fast_seconds, high_activity_time, high_active);
    end
    run_cycles(3 * TPS + 1, 0, -1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_pending got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_rate();
    do_reset();
    run_cycles(5 * TPS + 1, 6, -1);
    checks++;
    if (fast_seconds !== 4'd5 || high_activity_time !== TW'(5) || high_active !== 1'b1) begin
      errors++;
      $display("FAIL rate_final got=%0d/%0d/%0b required=5/5/1", fast_seconds, high_activity_time, high_active);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rate_pending got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_drop();
    do_reset();
    run_cycles(2 * TPS, 6, -1);
    run_cycles(TPS + 1, 0, -1);
    checks++;
    if (high_active !== 1'b0 || high_activity_time !== '0 || steps_last_sec !== 8'd0 || fast_seconds !== 4'd2) begin
      errors++;
      $display("FAIL drop_final got=%0b/%0d/%0d/%0d required=0/0/0/2", high_active, high_activity_time,
               steps_last_sec, fast_seconds);
    end
  endtask

  task automatic test_long();
    do_reset();
    run_cycles(12 * TPS + 1, 6, -1);
    checks++;
    if (fast_seconds !== 4'd9 || high_activity_time !== TW'(12)) begin
      errors++;
      $display("FAIL long_final got=%0d/%0d required=9/12", fast_seconds, high_activity_time);
    end
  endtask

  task automatic test_tick_edge();
    do_reset();
    run_cycles(TPS + 1, 0, TPS - 2);
    checks++;
    if (steps_last_sec !== 8'd1) begin
      errors++;
      $display("FAIL tick_edge_closing got=%0d required=1", steps_last_sec);
    end
    run_cycles(TPS, 0, TPS - 2);
    checks++;
    if (steps_last_sec !== 8'd0) begin
      errors++;
      $display("FAIL tick_edge_next got=%0d required=0", steps_last_sec);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_cycles(3 * TPS + 50, 6, -1);
    checks++;
    if (high_active !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_active got=%0b required=1", high_active);
    end
    reset = 1'b0;
    X = 1'b0;
    @(negedge clk100MHz);
    reset = 1'b1;
    model_clear();
    checks++;
    if ({sec_tick, steps_last_sec, fast_seconds, high_activity_time, high_active} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%0d/%0d/%0d/%0d/%0d required=all 0", sec_tick, steps_last_sec,
               fast_seconds, high_activity_time, high_active);
    end
    run_cycles(TPS + 1, 0, -1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_pending got=%0d required=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_drop();
    test_long();
    test_tick_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
